// File: rtl/accum_seq_pkg.sv
// Shared types and defaults for the frame-mean sequencer.
// State encoding and accumulator width live here.
package accum_seq_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int MAX_LOG2_DEF = 7;
  localparam int ACC_W        = DATA_W_DEF + MAX_LOG2_DEF;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    OUT
  } state_e;

endpackage

// File: rtl/accum_sequencer_core.sv
// Frame accumulator: synchronous clear, add-enable.
// Wide enough that a full frame of max samples cannot overflow.
module accum_core
  import accum_seq_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add_en,
  input  logic [W-1:0] add_val,
  output logic [W-1:0] acc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + add_val;
    end
  end

endmodule

// File: rtl/accum_sequencer.sv
// Collects 2**len_log2 samples, emits their truncated mean.
// Valid/ready on both sides; abort drops the frame silently.
module accum_sequencer
  import accum_seq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_LOG2 = MAX_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        len_log2,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int AW = DATA_W + MAX_LOG2;
  localparam int CW = MAX_LOG2 + 1;

  state_e        state, state_n;
  logic [2:0]    len_q, len_cl;
  logic [CW-1:0] cnt, n_m1;
  logic [AW-1:0] acc;
  logic          acc_clr, xfer, last;

  assign len_cl = (int'(len_log2) > MAX_LOG2)
                ? 3'(MAX_LOG2) : len_log2;
  assign n_m1   = (CW'(1) << len_q) - CW'(1);
  assign last   = (cnt == n_m1);
  assign xfer   = in_ready & in_valid;
  assign busy   = (state != IDLE);

  accum_core #(
    .W(AW)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .add_en  (xfer),
    .add_val (AW'(in_data)),
    .acc     (acc)
  );

  always_comb begin
    state_n  = state;
    acc_clr  = 1'b0;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = ACCUM;
          acc_clr = 1'b1;
        end
      end
      ACCUM: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          in_ready = 1'b1;
          if (in_valid && last) state_n = SCALE;
        end
      end
      SCALE: begin
        state_n = abort ? IDLE : OUT;
      end
      OUT: begin
        if (abort || out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= (state_n == OUT);
      if (state == IDLE && start) begin
        len_q <= len_cl;
        cnt   <= '0;
      end else if (xfer) begin
        cnt <= cnt + CW'(1);
      end
      // an aborted SCALE must leave the previous mean intact
      if (state == SCALE && !abort) begin
        out_data <= DATA_W'(acc >> len_q);
      end
    end
  end

endmodule
